// File: rtl/mux_arbiter16_pkg.sv
// Shared constants for the 16-way rotating-priority arbiter and its data mux.
package mux_arbiter16_pkg;

    localparam int NUM_REQ = 16;
    localparam int SEL_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux_arbiter16_mux16x1.sv
// Plain 16:1 single-bit multiplexer; the select comes straight from the arbiter's sel register.
module mux16x1
    import mux_arbiter16_pkg::*;
(
    input  logic [NUM_REQ-1:0] in,
    input  logic [SEL_W-1:0]   sel,
    output logic               out
);

    assign out = in[sel];

endmodule

// File: rtl/mux_arbiter16.sv
// Rotating-priority 16-way arbiter with a hold-time limit and a guaranteed dead cycle
// between owners; the granted requester's data bit is forwarded to data_out.
module mux_arbiter16
    import mux_arbiter16_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    input  logic [NUM_REQ-1:0] data_in,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic [SEL_W-1:0]   sel,
    output logic               data_out,
    output logic               timeout
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [7:0]         hold_cnt_q, hold_cnt_d;
    logic               timeout_q, timeout_d;

    logic               win_found;
    logic [SEL_W-1:0]   win_idx;
    logic [SEL_W-1:0]   cand;
    logic               rel_normal;
    logic               at_limit;
    logic               mux_out;

    // First requester at or after ptr, wrapping modulo 16.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ptr_q + SEL_W'(k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign rel_normal = done | ~req[sel_q];
    assign at_limit   = (hold_cnt_q == HOLD_LAST);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        timeout_d   = 1'b0;
        case (state_q)
            ST_IDLE, ST_GAP: begin
                if (win_found) begin
                    state_d     = ST_GRANT;
                    gnt_d       = onehot(win_idx);
                    gnt_valid_d = 1'b1;
                    sel_d       = win_idx;
                    hold_cnt_d  = '0;
                end else begin
                    state_d     = ST_IDLE;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                end
            end
            ST_GRANT: begin
                if (rel_normal || at_limit) begin
                    state_d     = ST_GAP;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    ptr_d       = sel_q + SEL_W'(1);
                    // A release that coincides with the limit is not a timeout.
                    timeout_d   = ~rel_normal;
                end else begin
                    hold_cnt_d  = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            sel_q       <= '0;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            sel_q       <= sel_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    mux16x1 u_mux (
        .in  (data_in),
        .sel (sel_q),
        .out (mux_out)
    );

    assign data_out  = mux_out & gnt_valid_q;
    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign sel       = sel_q;
    assign timeout   = timeout_q;

endmodule
